// File: rtl/lnet_pkg.sv
// Shared definitions for the LUT-network layer skid buffer: state encoding
// and default widths.
package lnet_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_CNT_W = 16;

endpackage : lnet_pkg

// File: rtl/lnet_sat_cnt.sv
// Saturating event counter: counts cycles with inc=1 and holds at all-ones.
module lnet_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : lnet_sat_cnt

// File: rtl/lnet_layer_skid.sv
// Two-entry skid buffer between LUT layers; s_ready is registered so it never
// depends on m_ready. Define LNET_SKID_STATS_EN to add transfer/stall counters.
//
// state | meaning
// EMPTY | nothing held, m_valid=0
// ONE   | main register valid
// FULL  | main and skid registers valid, s_ready=0
module lnet_layer_skid
    import lnet_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IN_W-1:0]  m_data
`ifdef LNET_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (IN_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("lnet_layer_skid: IN_W and CNT_W must be at least 1");
    end

    skid_state_e     state, state_nx;
    logic [IN_W-1:0] main_q, skid_q, main_nx;
    logic            ready_q;
    logic            load_main, load_skid, main_from_skid;
    logic            in_xfer, out_xfer;

    assign s_ready  = ready_q;
    assign m_valid  = (state != EMPTY);
    assign m_data   = main_q;
    assign in_xfer  = s_valid && ready_q;
    assign out_xfer = m_valid && m_ready;
    assign main_nx  = main_from_skid ? skid_q : s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != FULL);
            if (load_main) main_q <= main_nx;
            if (load_skid) skid_q <= s_data;
        end
    end

    always_comb begin
        state_nx       = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nx  = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_nx  = FULL;
                    load_skid = 1'b1;
                end else if (!in_xfer && out_xfer) begin
                    state_nx = EMPTY;
                end else if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                // ready_q is low here, so the skid entry is the only source
                if (out_xfer) begin
                    state_nx       = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

`ifdef LNET_SKID_STATS_EN
    lnet_sat_cnt #(.CNT_W(CNT_W)) u_xfer_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_xfer),
        .cnt (xfer_cnt)
    );

    lnet_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (m_valid && !m_ready),
        .cnt (stall_cnt)
    );
`endif

endmodule : lnet_layer_skid

// File: tb/tb_lnet_layer_skid.sv
// Self-checking bench for lnet_layer_skid: directed cases plus a randomized
// run against a queue-based reference of a two-deep FIFO.
module tb_lnet_layer_skid;

    localparam int IN_W  = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic             m_valid;
    logic             m_ready;
    logic [IN_W-1:0]  m_data;
`ifdef LNET_SKID_STATS_EN
    logic [CNT_W-1:0] xfer_cnt;
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lnet_layer_skid #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
`ifdef LNET_SKID_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [IN_W-1:0] q[$];
        logic [IN_W-1:0] prev_data;
        logic            prev_stall;
        int              exp_out;
        int              n_x, n_s;

        // reset values
        do_reset();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_data",  32'(m_data),  32'd0);

        // single vector, one-cycle latency from EMPTY
        s_valid = 1'b1; s_data = 16'hA5C3; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("lat_m_valid", 32'(m_valid), 32'd1);
        chk("lat_m_data",  32'(m_data),  32'hA5C3);
        chk("lat_s_ready", 32'(s_ready), 32'd1);
        step();
        chk("lat_drain", 32'(m_valid), 32'd0);

        // fill to FULL under backpressure, then drain in order
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'h0001;
        step();
        chk("bp_ready1", 32'(s_ready), 32'd1);
        s_data = 16'h0002;
        step();
        s_valid = 1'b0;
        chk("bp_ready2", 32'(s_ready), 32'd0);
        chk("bp_hold0",  32'(m_data),  32'h0001);
        step();
        step();
        chk("bp_hold1", 32'(m_data), 32'h0001);
        s_valid = 1'b1; s_data = 16'hDEAD;  // must be ignored while FULL
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("bp_out2",   32'(m_data),  32'h0002);
        chk("bp_valid2", 32'(m_valid), 32'd1);
        step();
        chk("bp_empty", 32'(m_valid), 32'd0);

        // 100-cycle stream, s_ready must never drop
        exp_out = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_data = 16'(i + 16'h0100);
            chk("str_s_ready", 32'(s_ready), 32'd1);
            if (m_valid) begin
                chk("str_data", 32'(m_data), 32'(exp_out + 16'h0100));
                exp_out++;
            end
            step();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (m_valid) begin
                chk("str_data", 32'(m_data), 32'(exp_out + 16'h0100));
                exp_out++;
            end
            step();
        end
        chk("str_count", 32'(exp_out), 32'd100);

        // reset while FULL discards everything
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'h1111; step();
        s_data = 16'h2222; step();
        s_valid = 1'b0;
        chk("full_before_rst", 32'(s_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("frst_m_valid", 32'(m_valid), 32'd0);
        chk("frst_s_ready", 32'(s_ready), 32'd1);
        chk("frst_m_data",  32'(m_data),  32'd0);

`ifdef LNET_SKID_STATS_EN
        // 20 transfers saturate a 4-bit counter; then 3 stall cycles
        do_reset();
        chk("cnt_rst_x", 32'(xfer_cnt),  32'd0);
        chk("cnt_rst_s", 32'(stall_cnt), 32'd0);
        n_x = 0; n_s = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            s_valid = 1'b1; s_data = 16'(i);
            if (m_valid && m_ready) n_x++;
            step();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (m_valid && !m_ready) n_s++;
            step();
        end
        chk("cnt_xfers_seen", 32'(n_x), 32'd20);
        chk("cnt_xfer",  32'(xfer_cnt),  32'(n_x > 15 ? 15 : n_x));
        chk("cnt_stall", 32'(stall_cnt), 32'(n_s));
        chk("cnt_stall_3", 32'(stall_cnt), 32'd3);
        rst = 1'b1; step(); rst = 1'b0;
        chk("cnt_rst2_x", 32'(xfer_cnt), 32'd0);
`endif

        // randomized traffic against a queue model of a 2-deep FIFO
        do_reset();
        q.delete();
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            chk("rnd_m_valid", 32'(m_valid), 32'(q.size() != 0));
            chk("rnd_s_ready", 32'(s_ready), 32'(q.size() < 2));
            if (q.size() != 0) chk("rnd_m_data", 32'(m_data), 32'(q[0]));
            if (prev_stall) chk("rnd_stable", 32'(m_data), 32'(prev_data));
            s_valid = ($urandom_range(0, 99) < 60);
            m_ready = ($urandom_range(0, 99) < 55);
            s_data  = 16'($urandom);
            prev_stall = (q.size() != 0) && !m_ready;
            prev_data  = m_data;
            if ((q.size() != 0) && m_ready) void'(q.pop_front());
            if (s_valid && (q.size() + ((q.size() != 0 || !m_ready) ? 0 : 0) < 2)
                && s_ready) q.push_back(s_data);
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (q.size() != 0) begin
                chk("rnd_drain", 32'(m_data), 32'(q[0]));
                void'(q.pop_front());
            end
            step();
        end
        chk("rnd_final_empty", 32'(m_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_lnet_layer_skid
